// File: rtl/sdr_device_model_if.sv
// rtl/sdr_device_model_if.sv - SDRAM pin bundle between sdr_controller and sdr_device_model
// Purpose: groups the SDRAM command/address/data pins into one bus.
// Signals:
//   sdram_cle               clock enable; commands ignored while low
//   sdram_cs/ras/cas/we     command, encoded as {cs,ras,cas,we}
//   sdram_dqm               write mask
//   sdram_ba, sdram_a       bank and address
//   dq_in                   write data from the controller
//   dq_out, dq_oe           read data and its valid strobe from the device
// Modports: master = controller side, slave = device side.
interface sdr_device_model_if;
  logic        sdram_cle;
  logic        sdram_cs;
  logic        sdram_ras;
  logic        sdram_cas;
  logic        sdram_we;
  logic        sdram_dqm;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [31:0] dq_in;
  logic [31:0] dq_out;
  logic        dq_oe;

  modport master (
    output sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we,
    output sdram_dqm, sdram_ba, sdram_a, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we,
    input  sdram_dqm, sdram_ba, sdram_a, dq_in,
    output dq_out, dq_oe
  );
endinterface

// File: rtl/sdr_device_model.sv
// rtl/sdr_device_model.sv - synthesizable SDR SDRAM device responder with protocol checks
// Purpose: decodes the SDRAM command bus, keeps per-bank open-row state, stores
// write data in an internal array, returns read data after the programmed CAS
// latency and raises sticky flags on illegal commands and timing violations.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   bus             sdr_device_model_if.slave (command, address, dq_in, dq_out, dq_oe)
//   open_rows       per-bank open flag
//   refresh_count   accepted REFRESH commands, saturating at 0xFFFF
//   err_cmd         sticky illegal-command flag
//   err_timing      sticky TRCD/TRP/TRFC violation flag
//   err_refresh     sticky refresh-interval violation flag
module sdr_device_model #(
  parameter int ROW_W       = 4,
  parameter int COL_W       = 6,
  parameter int CL_DEFAULT  = 2,
  parameter int TRCD        = 3,
  parameter int TRP         = 3,
  parameter int TRFC        = 7,
  parameter int REFRESH_MAX = 1000
) (
  input  logic                clk,
  input  logic                rst,
  sdr_device_model_if.slave   bus,
  output logic [3:0]          open_rows,
  output logic [15:0]         refresh_count,
  output logic                err_cmd,
  output logic                err_timing,
  output logic                err_refresh
);

  localparam int ADDR_W = 2 + ROW_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RINT_W = $clog2(REFRESH_MAX + 2);

  localparam logic [7:0]        TCNT_SAT = 8'hFF;
  localparam logic [7:0]        TRCD_C   = 8'(TRCD);
  localparam logic [7:0]        TRP_C    = 8'(TRP);
  localparam logic [7:0]        TRFC_C   = 8'(TRFC);
  localparam logic [RINT_W-1:0] RINT_MAX = RINT_W'(REFRESH_MAX);
  localparam logic [RINT_W-1:0] RINT_SAT = '1;

  // {ras,cas,we} once cs is known to be low
  localparam logic [2:0] OP_LMR = 3'b000;
  localparam logic [2:0] OP_REF = 3'b001;
  localparam logic [2:0] OP_PRE = 3'b010;
  localparam logic [2:0] OP_ACT = 3'b011;
  localparam logic [2:0] OP_WR  = 3'b100;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic {BANK_IDLE = 1'b0, BANK_OPEN = 1'b1} bank_state_t;

  logic [31:0] mem [DEPTH];

  bank_state_t       bank_q [4];
  bank_state_t       bank_d [4];
  logic [ROW_W-1:0]  row_q [4];
  logic [ROW_W-1:0]  row_d [4];
  logic [7:0]        bank_cnt_q [4];
  logic [7:0]        bank_cnt_d [4];
  logic [7:0]        ref_cnt_q, ref_cnt_d;
  logic [RINT_W-1:0] rint_q, rint_d;
  logic [1:0]        cl_q, cl_d;
  logic [15:0]       rcount_d;
  logic              err_cmd_d, err_timing_d, err_refresh_d;

  // Read pipeline: s1 -> s0 -> dq_out. CL=3 enters s1, CL=2 enters s0,
  // CL=1 loads the output register on the READ edge itself.
  logic        s0_v_q, s0_v_d, s1_v_q, s1_v_d;
  logic [31:0] s0_d_q, s0_d_d, s1_d_q, s1_d_d;
  logic        oe_d;
  logic [31:0] out_d;

  logic              cmd_en;
  logic [2:0]        op;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       rd_data;
  logic              mem_we;
  logic              any_open;
  logic              unused_a;

  assign cmd_en   = bus.sdram_cle & ~bus.sdram_cs & ~rst;
  assign op       = {bus.sdram_ras, bus.sdram_cas, bus.sdram_we};
  assign acc_addr = {bus.sdram_ba, row_q[bus.sdram_ba], bus.sdram_a[COL_W-1:0]};
  assign rd_data  = mem[acc_addr];
  assign any_open = |open_rows;
  assign unused_a = ^bus.sdram_a;

  always_comb begin
    for (int i = 0; i < 4; i++) open_rows[i] = (bank_q[i] == BANK_OPEN);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bank_d[i]     = bank_q[i];
      row_d[i]      = row_q[i];
      bank_cnt_d[i] = (bank_cnt_q[i] == TCNT_SAT) ? TCNT_SAT : bank_cnt_q[i] + 8'd1;
    end
    ref_cnt_d     = (ref_cnt_q == TCNT_SAT) ? TCNT_SAT : ref_cnt_q + 8'd1;
    rint_d        = !bus.sdram_cle ? '0 : ((rint_q == RINT_SAT) ? RINT_SAT : rint_q + 1'b1);
    cl_d          = cl_q;
    rcount_d      = refresh_count;
    err_cmd_d     = err_cmd;
    err_timing_d  = err_timing;
    err_refresh_d = err_refresh | (rint_q > RINT_MAX);
    mem_we        = 1'b0;

    oe_d   = s0_v_q;
    out_d  = s0_v_q ? s0_d_q : bus.dq_out;
    s0_v_d = s1_v_q;
    s0_d_d = s1_d_q;
    s1_v_d = 1'b0;
    s1_d_d = s1_d_q;

    if (cmd_en) begin
      if (op != OP_NOP && ref_cnt_q < TRFC_C) err_timing_d = 1'b1;
      case (op)
        OP_ACT: begin
          if (bank_q[bus.sdram_ba] == BANK_OPEN) begin
            err_cmd_d = 1'b1;
          end else begin
            if (bank_cnt_q[bus.sdram_ba] < TRP_C) err_timing_d = 1'b1;
            bank_d[bus.sdram_ba]     = BANK_OPEN;
            row_d[bus.sdram_ba]      = bus.sdram_a[ROW_W-1:0];
            bank_cnt_d[bus.sdram_ba] = 8'd1;
          end
        end
        OP_RD: begin
          if (bank_q[bus.sdram_ba] != BANK_OPEN) begin
            err_cmd_d = 1'b1;
          end else begin
            if (bank_cnt_q[bus.sdram_ba] < TRCD_C) err_timing_d = 1'b1;
            case (cl_q)
              2'd1: begin
                oe_d  = 1'b1;
                out_d = rd_data;
              end
              2'd2: begin
                s0_v_d = 1'b1;
                s0_d_d = rd_data;
              end
              default: begin
                s1_v_d = 1'b1;
                s1_d_d = rd_data;
              end
            endcase
          end
        end
        OP_WR: begin
          if (bank_q[bus.sdram_ba] != BANK_OPEN) begin
            err_cmd_d = 1'b1;
          end else begin
            if (bank_cnt_q[bus.sdram_ba] < TRCD_C) err_timing_d = 1'b1;
            mem_we = ~bus.sdram_dqm;
          end
        end
        OP_PRE: begin
          for (int i = 0; i < 4; i++) begin
            if (bus.sdram_a[10] || bus.sdram_ba == 2'(i)) begin
              bank_d[i]     = BANK_IDLE;
              bank_cnt_d[i] = 8'd1;
            end
          end
        end
        OP_REF: begin
          if (any_open) err_cmd_d = 1'b1;
          rcount_d  = (refresh_count == 16'hFFFF) ? 16'hFFFF : refresh_count + 16'd1;
          ref_cnt_d = 8'd1;
          rint_d    = '0;
        end
        OP_LMR: begin
          // Accept only CL 1..3 (a[6]=0, a[5:4]!=0) with every bank idle
          if (any_open || bus.sdram_a[6] || bus.sdram_a[5:4] == 2'd0) err_cmd_d = 1'b1;
          else cl_d = bus.sdram_a[5:4];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        bank_q[i]     <= BANK_IDLE;
        row_q[i]      <= '0;
        bank_cnt_q[i] <= TCNT_SAT;
      end
      ref_cnt_q     <= TCNT_SAT;
      rint_q        <= '0;
      cl_q          <= 2'(CL_DEFAULT);
      refresh_count <= '0;
      err_cmd       <= 1'b0;
      err_timing    <= 1'b0;
      err_refresh   <= 1'b0;
      s0_v_q        <= 1'b0;
      s0_d_q        <= '0;
      s1_v_q        <= 1'b0;
      s1_d_q        <= '0;
      bus.dq_oe     <= 1'b0;
      bus.dq_out    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        bank_q[i]     <= bank_d[i];
        row_q[i]      <= row_d[i];
        bank_cnt_q[i] <= bank_cnt_d[i];
      end
      ref_cnt_q     <= ref_cnt_d;
      rint_q        <= rint_d;
      cl_q          <= cl_d;
      refresh_count <= rcount_d;
      err_cmd       <= err_cmd_d;
      err_timing    <= err_timing_d;
      err_refresh   <= err_refresh_d;
      s0_v_q        <= s0_v_d;
      s0_d_q        <= s0_d_d;
      s1_v_q        <= s1_v_d;
      s1_d_q        <= s1_d_d;
      bus.dq_oe     <= oe_d;
      bus.dq_out    <= out_d;
    end
  end

  // Array contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_addr] <= bus.dq_in;
  end

endmodule

// File: tb/tb_sdr_device_model.sv
// tb/tb_sdr_device_model.sv - scoreboard testbench for sdr_device_model
// Purpose: drives directed and random SDRAM command streams, predicts read data,
// read timing and flag values from an edge-numbered reference model.
// Ports: none (top-level bench).
module tb_sdr_device_model;
  localparam int ROW_W = 4, COL_W = 6, TRCD = 3, TRP = 3, TRFC = 7, REFRESH_MAX = 1000;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_TERM = 4'b0110, C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  open_rows;
  logic [15:0] refresh_count;
  logic        err_cmd, err_timing, err_refresh;

  sdr_device_model_if bus ();

  sdr_device_model #(
    .ROW_W(ROW_W), .COL_W(COL_W), .CL_DEFAULT(2), .TRCD(TRCD), .TRP(TRP),
    .TRFC(TRFC), .REFRESH_MAX(REFRESH_MAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .open_rows(open_rows),
    .refresh_count(refresh_count), .err_cmd(err_cmd), .err_timing(err_timing),
    .err_refresh(err_refresh)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  // Reference model: bank state plus the edge number of the last event
  bit          m_open [4];
  int          m_row [4];
  int          m_last_bank [4];
  int          m_last_ref, m_clear, m_cl, m_rcount;
  bit          m_err_cmd, m_err_timing, m_err_ref;
  logic [31:0] m_mem [int];

  task automatic model_reset(input int r);
    for (int i = 0; i < 4; i++) begin
      m_open[i] = 0; m_row[i] = 0; m_last_bank[i] = -1000;
    end
    m_last_ref = -1000; m_clear = r; m_cl = 2; m_rcount = 0;
    m_err_cmd = 0; m_err_timing = 0; m_err_ref = 0;
  endtask

  task automatic model_edge(input int e_n, input logic [3:0] c, input logic [1:0] ba,
                            input logic [12:0] a, input logic [31:0] d, input logic dqm,
                            input logic cle);
    int   key;
    bit   any;
    exp_t e;
    if (e_n - 1 - m_clear > REFRESH_MAX) m_err_ref = 1;
    if (!cle) m_clear = e_n;
    if (cle && !c[3]) begin
      any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
      if (c != C_NOP && e_n - m_last_ref < TRFC) m_err_timing = 1;
      key = (int'(ba) << (ROW_W + COL_W)) + (m_row[ba] << COL_W) + int'(a[COL_W-1:0]);
      case (c)
        C_ACT: if (m_open[ba]) m_err_cmd = 1;
               else begin
                 if (e_n - m_last_bank[ba] < TRP) m_err_timing = 1;
                 m_open[ba] = 1; m_row[ba] = int'(a[ROW_W-1:0]); m_last_bank[ba] = e_n;
               end
        C_RD: if (!m_open[ba]) m_err_cmd = 1;
              else begin
                if (e_n - m_last_bank[ba] < TRCD) m_err_timing = 1;
                e.cyc = e_n + m_cl - 1;
                e.chk = m_mem.exists(key);
                e.data = e.chk ? m_mem[key] : 32'h0;
                exp_q.push_back(e);
              end
        C_WR: if (!m_open[ba]) m_err_cmd = 1;
              else begin
                if (e_n - m_last_bank[ba] < TRCD) m_err_timing = 1;
                if (!dqm) m_mem[key] = d;
              end
        C_PRE: for (int i = 0; i < 4; i++)
                 if (a[10] || int'(ba) == i) begin m_open[i] = 0; m_last_bank[i] = e_n; end
        C_REF: begin
          if (any) m_err_cmd = 1;
          if (m_rcount < 65535) m_rcount++;
          m_last_ref = e_n; m_clear = e_n;
        end
        C_LMR: if (any || a[6:4] < 3'd1 || a[6:4] > 3'd3) m_err_cmd = 1;
               else m_cl = int'(a[6:4]);
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [31:0] d, input logic dqm, input logic cle);
    bus.sdram_cle = cle;
    {bus.sdram_cs, bus.sdram_ras, bus.sdram_cas, bus.sdram_we} = c;
    bus.sdram_ba = ba; bus.sdram_a = a; bus.dq_in = d; bus.sdram_dqm = dqm;
    model_edge(edge_n + 1, c, ba, a, d, dqm, cle);
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sdram_cle = 1'b1;
    {bus.sdram_cs, bus.sdram_ras, bus.sdram_cas, bus.sdram_we} = C_NOP;
    bus.sdram_ba = '0; bus.sdram_a = '0; bus.dq_in = '0; bus.sdram_dqm = 1'b0;
    exp_q.delete();
    repeat (2) begin @(posedge clk); edge_n++; end
    #1;
    rst = 1'b0;
    model_reset(edge_n);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(C_NOP, 2'd0, 13'd0, 32'd0, 1'b0, 1'b1);
  endtask
  task automatic act(input logic [1:0] ba, input int row);
    drive(C_ACT, ba, 13'(row), 32'd0, 1'b0, 1'b1);
  endtask
  task automatic rd(input logic [1:0] ba, input int col);
    drive(C_RD, ba, 13'(col), 32'd0, 1'b0, 1'b1);
  endtask
  task automatic wr(input logic [1:0] ba, input int col, input logic [31:0] d, input logic dqm);
    drive(C_WR, ba, 13'(col), d, dqm, 1'b1);
  endtask
  task automatic pre(input logic [1:0] ba, input bit all);
    drive(C_PRE, ba, all ? 13'h400 : 13'h0, 32'd0, 1'b0, 1'b1);
  endtask
  task automatic refr();
    drive(C_REF, 2'd0, 13'd0, 32'd0, 1'b0, 1'b1);
  endtask
  task automatic lmr(input int v);
    drive(C_LMR, 2'd0, 13'(v) << 4, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act_v, exp_v, edge_n);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".err_cmd"}, 32'(err_cmd), 32'(m_err_cmd));
    chk({tag, ".err_timing"}, 32'(err_timing), 32'(m_err_timing));
    chk({tag, ".err_refresh"}, 32'(err_refresh), 32'(m_err_ref));
    chk({tag, ".open_rows"}, 32'(open_rows), 32'({m_open[3], m_open[2], m_open[1], m_open[0]}));
    chk({tag, ".refresh_count"}, 32'(refresh_count), 32'(m_rcount));
  endtask

  // Monitor: every read response must arrive on its predicted edge with its data
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        e = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL rd_missing: response due at edge %0d absent, now edge %0d", e.cyc, edge_n);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.dq_oe !== 1'b1 || (e.chk && bus.dq_out !== e.data)) begin
          n_bad++;
          $display("FAIL rd_data: edge %0d got oe=%b data=%h expected oe=1 data=%h",
                   edge_n, bus.dq_oe, bus.dq_out, e.data);
        end
      end else if (bus.dq_oe !== 1'b0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_unexpected: edge %0d got oe=%b expected oe=0", edge_n, bus.dq_oe);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    int          r;
    logic [1:0]  rba;
    logic [12:0] ra;
    logic [3:0]  rc;

    // Reset values and basic write/read at CL=2
    do_reset();
    chk("rst.dq_oe", 32'(bus.dq_oe), 32'd0);
    chk("rst.dq_out", bus.dq_out, 32'd0);
    chk("rst.open_rows", 32'(open_rows), 32'd0);
    chk("rst.refresh_count", 32'(refresh_count), 32'd0);
    chk("rst.errs", 32'({err_cmd, err_timing, err_refresh}), 32'd0);
    nop(5);
    act(2'd1, 5);
    nop(3);
    wr(2'd1, 3, 32'hDEADBEEF, 1'b0);
    nop(1);
    rd(2'd1, 3);
    nop(3);
    chk("basic.open_rows", 32'(open_rows), 32'h2);
    chk("basic.errs", 32'({err_cmd, err_timing, err_refresh}), 32'd0);
    chk_flags("basic");

    // Back-to-back reads at CL=2, then at CL=3
    act(2'd0, 2);
    nop(3);
    for (int i = 0; i < 3; i++) wr(2'd0, i, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) rd(2'd0, i);
    nop(3);
    pre(2'd0, 1'b1);
    lmr(3);
    act(2'd0, 2);
    nop(3);
    for (int i = 0; i < 3; i++) rd(2'd0, i);
    nop(4);
    // Masked write leaves the location untouched
    wr(2'd0, 5, 32'h11111111, 1'b0);
    wr(2'd0, 5, 32'h22222222, 1'b1);
    rd(2'd0, 5);
    nop(4);
    chk_flags("b2b");

    // Read to an idle bank
    do_reset();
    rd(2'd2, 0);
    nop(3);
    chk("idle_rd.err_cmd", 32'(err_cmd), 32'd1);
    chk_flags("idle_rd");

    // TRP boundary legal, TRCD violation still returns data
    do_reset();
    act(2'd2, 1);
    nop(3);
    wr(2'd2, 7, 32'hCAFEF00D, 1'b0);
    pre(2'd2, 1'b0);
    nop(2);
    act(2'd2, 1);
    chk("trp_edge.err_timing", 32'(err_timing), 32'd0);
    nop(1);
    rd(2'd2, 7);
    nop(3);
    chk("trcd_viol.err_timing", 32'(err_timing), 32'd1);
    chk_flags("trcd_viol");

    // TRCD boundary legal; precharge-all then refresh; TRFC violation
    do_reset();
    act(2'd3, 0);
    nop(2);
    rd(2'd3, 0);
    nop(2);
    chk("trcd_edge.err_timing", 32'(err_timing), 32'd0);
    pre(2'd0, 1'b1);
    refr();
    chk("ref.open_rows", 32'(open_rows), 32'd0);
    chk("ref.refresh_count", 32'(refresh_count), 32'd1);
    nop(5);
    act(2'd0, 0);
    chk("trfc_viol.err_timing", 32'(err_timing), 32'd1);
    chk_flags("trfc_viol");
    do_reset();
    refr();
    nop(6);
    act(2'd0, 0);
    chk("trfc_edge.err_timing", 32'(err_timing), 32'd0);

    // Illegal command cases
    act(2'd0, 1);
    chk("act_open.err_cmd", 32'(err_cmd), 32'd1);
    chk_flags("act_open");
    do_reset();
    act(2'd0, 0);
    nop(7);
    lmr(1);
    chk("lmr_open.err_cmd", 32'(err_cmd), 32'd1);
    do_reset();
    lmr(4);
    chk("lmr_bad.err_cmd", 32'(err_cmd), 32'd1);
    do_reset();
    act(2'd0, 0);
    nop(7);
    refr();
    chk("ref_open.err_cmd", 32'(err_cmd), 32'd1);
    chk("ref_open.refresh_count", 32'(refresh_count), 32'd1);

    // Reset mid-read flushes the pipeline
    do_reset();
    lmr(3);
    act(2'd1, 3);
    nop(3);
    rd(2'd1, 3);
    do_reset();
    chk("rst_flush.dq_oe", 32'(bus.dq_oe), 32'd0);
    nop(3);

    // cle low blocks decode but not the read pipeline
    act(2'd1, 3);
    nop(3);
    wr(2'd1, 4, 32'h0BADF00D, 1'b0);
    rd(2'd1, 4);
    drive(C_ACT, 2'd2, 13'd1, 32'd0, 1'b0, 1'b0);
    drive(C_NOP, 2'd0, 13'd0, 32'd0, 1'b0, 1'b0);
    nop(2);
    chk("cle_low.open_rows", 32'(open_rows), 32'h2);
    chk_flags("cle_low");

    // Refresh-interval limit and its clearing by cle low
    do_reset();
    nop(995);
    chk("rint_below.err_refresh", 32'(err_refresh), 32'd0);
    nop(10);
    chk("rint_over.err_refresh", 32'(err_refresh), 32'd1);
    chk_flags("rint_over");
    do_reset();
    nop(900);
    drive(C_NOP, 2'd0, 13'd0, 32'd0, 1'b0, 1'b0);
    nop(900);
    chk("rint_cle.err_refresh", 32'(err_refresh), 32'd0);
    chk_flags("rint_cle");

    // Random command streams against the model
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int k = 0; k < 100; k++) begin
        r   = $urandom_range(0, 99);
        rba = 2'($urandom_range(0, 3));
        ra  = 13'($urandom_range(0, 3));
        ra[10] = 1'($urandom_range(0, 1));
        if (r < 20) rc = C_ACT;
        else if (r < 42) rc = C_RD;
        else if (r < 57) rc = C_WR;
        else if (r < 66) rc = C_PRE;
        else if (r < 72) rc = C_REF;
        else if (r < 75) rc = C_LMR;
        else if (r < 78) rc = C_TERM;
        else if (r < 80) rc = 4'b1000 | 4'($urandom_range(0, 7));
        else rc = C_NOP;
        if (rc == C_LMR) ra[6:4] = 3'($urandom_range(0, 4));
        drive(rc, rba, ra, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) != 0));
        if (k % 25 == 24) chk_flags("rand");
      end
      nop(4);
      chk_flags("rand_end");
    end

    nop(4);
    chk("drain.exp_q", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
